// File: rtl/c1_reduce_seq_pkg.sv
// Shared definitions for the sequential C1 reduction unit: mode and state
// encodings, the C1 cell primitive and the mode decoder.
// Optional feature macro: C1_REDUCE_XOR_EN (enables the XOR/parity mode).
package c1_reduce_seq_pkg;

  // Reduction mode encodings (input port "mode")
  localparam logic [1:0] MODE_AND = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // C1 cell: a 2:1 multiplexer, SA selects A1 when high and A0 when low.
  function automatic logic c1_cell(input logic sa, input logic a1, input logic a0);
    return sa ? a1 : a0;
  endfunction

  // Map the requested mode onto the mode the hardware actually implements.
  // Reserved (and XOR when the XOR path is not built) fall back to AND.
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    logic [1:0] eff;
    eff = MODE_AND;
    case (m)
      MODE_OR:  eff = MODE_OR;
`ifdef C1_REDUCE_XOR_EN
      MODE_XOR: eff = MODE_XOR;
`endif
      default:  eff = MODE_AND;
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/c1_slice_reduce.sv
// Combinational slice reducer: folds a P-bit slice into the running
// accumulator using chains of C1 cells, one cell per slice bit.
// Optional feature macro: C1_REDUCE_XOR_EN (adds the XOR chain).
module c1_slice_reduce
  import c1_reduce_seq_pkg::*;
#(
  parameter int P = 4
) (
  input  logic [P-1:0] slice,
  input  logic         acc,
  input  logic [1:0]   mode,
  output logic         next_acc
);

  logic [P:0] and_chain;
  logic [P:0] or_chain;
`ifdef C1_REDUCE_XOR_EN
  logic [P:0] xor_chain;
`endif

  // Cell chains seeded with the accumulator. AND: bit gates the chain via SA,
  // A0 tied low. OR: bit on SA selects A1=1, otherwise passes the chain on A0.
  always_comb begin
    and_chain    = '0;
    or_chain     = '0;
    and_chain[0] = acc;
    or_chain[0]  = acc;
    for (int i = 0; i < P; i++) begin
      and_chain[i+1] = c1_cell(slice[i], and_chain[i], 1'b0);
      or_chain[i+1]  = c1_cell(slice[i], 1'b1, or_chain[i]);
    end
  end

`ifdef C1_REDUCE_XOR_EN
  // XOR chain: bit on SA selects the inverted chain value, else passes it.
  always_comb begin
    xor_chain    = '0;
    xor_chain[0] = acc;
    for (int i = 0; i < P; i++) begin
      xor_chain[i+1] = c1_cell(slice[i], ~xor_chain[i], xor_chain[i]);
    end
  end
`endif

  // Pick the chain that matches the effective mode.
  always_comb begin
    next_acc = and_chain[P];
    case (decode_mode(mode))
      MODE_OR:  next_acc = or_chain[P];
`ifdef C1_REDUCE_XOR_EN
      MODE_XOR: next_acc = xor_chain[P];
`endif
      default:  next_acc = and_chain[P];
    endcase
  end

endmodule

// File: rtl/c1_reduce_seq.sv
// Sequential N-bit to 1-bit reduction unit, P bits per clock, LSB slice first,
// with AND/OR modes, early termination and a start/done handshake.
// Optional feature macro: C1_REDUCE_XOR_EN (mode 10 selects XOR/parity).
//
// Handshake: start is sampled only in IDLE; the accepting edge latches in and
// mode, after which both are don't-care. busy is high in RUN and DONE, done is
// a one-cycle pulse in DONE marking out as valid, and out holds its value
// until the next operation completes. start seen in RUN/DONE is dropped.
module c1_reduce_seq
  import c1_reduce_seq_pkg::*;
#(
  parameter int N = 16,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [N-1:0] in,
  output logic         busy,
  output logic         done,
  output logic         out,
  output logic [1:0]   dbg_state
);

  localparam int S  = N / P;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

  logic [1:0]    state;
  logic [N-1:0]  sr;
  logic [IW-1:0] idx;
  logic          acc;
  logic [1:0]    mreg;

  logic          acc_next;
  logic [1:0]    eff_mode;
  logic          early;
  logic          finish;
  logic          init_acc;

  c1_slice_reduce #(.P(P)) u_slice (
    .slice    (sr[P-1:0]),
    .acc      (acc),
    .mode     (mreg),
    .next_acc (acc_next)
  );

  // Termination decision for the slice being processed this cycle.
  always_comb begin
    eff_mode = decode_mode(mreg);
    early    = ((eff_mode == MODE_AND) && !acc_next) ||
               ((eff_mode == MODE_OR)  &&  acc_next);
    finish   = (idx == LAST_IDX) || early;
    init_acc = (decode_mode(mode) == MODE_AND);
  end

  // FSM plus datapath registers; reset aborts any operation and clears out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sr    <= '0;
      idx   <= '0;
      acc   <= 1'b0;
      mreg  <= MODE_AND;
      out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sr    <= in;
            mreg  <= mode;
            idx   <= '0;
            acc   <= init_acc;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          sr  <= sr >> P;
          if (finish) begin
            out   <= acc_next;
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_c1_reduce_seq.sv
// Directed self-checking bench for c1_reduce_seq (N=16, P=4, S=4).
// Honours C1_REDUCE_XOR_EN when choosing expected values for mode 10.
module tb_c1_reduce_seq;

  localparam logic [1:0] M_AND = 2'b00;
  localparam logic [1:0] M_OR  = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] in = 16'h0000;
  logic        busy;
  logic        done;
  logic        out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  c1_reduce_seq #(.N(16), .P(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in        (in),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: accept one operation, then follow it until done and one cycle on.
  // lat = cycles from the accepting edge to the done cycle (-1 on timeout),
  // busy_cnt = cycles with busy high, done2 = done in the cycle after done.
  task automatic do_op(input logic [1:0] m, input logic [15:0] d,
                       output int lat, output int busy_cnt,
                       output logic res, output logic done2);
    start = 1'b1;
    mode  = m;
    in    = d;
    tick();
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    in    = 16'($urandom_range(0, 65535));
    lat = -1; busy_cnt = 0; res = 1'b0; done2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (lat >= 0) begin
        done2 = done;
        break;
      end
      if (done) begin
        lat = c;
        res = out;
      end
      tick();
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] m, input logic [15:0] d,
                          input int exp_lat, input logic exp_out);
    int lat, bc;
    logic res, d2;
    do_op(m, d, lat, bc, res, d2);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (res !== exp_out) begin
      errors++;
      $display("FAIL %s out got %0b expected %0b", name, res, exp_out);
    end
    checks++;
    if (bc !== exp_lat + 1) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected %0d", name, bc, exp_lat + 1);
    end
    checks++;
    if (d2 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got %0b expected 0", name, d2);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, out, dbg_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset busy/done/out/state got %b expected 00000",
               {busy, done, out, dbg_state});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, done, out} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got %b expected 000", {busy, done, out});
    end
  endtask

  task automatic test_and();
    check_op("and_ffff", M_AND, 16'hFFFF, 4, 1'b1);
    check_op("and_fff0", M_AND, 16'hFFF0, 1, 1'b0);
    check_op("and_0fff", M_AND, 16'h0FFF, 4, 1'b0);
    check_op("rsv_ffff", M_RSV, 16'hFFFF, 4, 1'b1);
  endtask

  task automatic test_or();
    check_op("or_1000", M_OR, 16'h1000, 4, 1'b1);
    check_op("or_0000", M_OR, 16'h0000, 4, 1'b0);
    check_op("or_0010", M_OR, 16'h0010, 2, 1'b1);
  endtask

  task automatic test_xor();
`ifdef C1_REDUCE_XOR_EN
    check_op("xor_0007", M_XOR, 16'h0007, 4, 1'b1);
    check_op("xor_8421", M_XOR, 16'h8421, 4, 1'b0);
`else
    check_op("xor_as_and_0007", M_XOR, 16'h0007, 1, 1'b0);
    check_op("xor_as_and_ffff", M_XOR, 16'hFFFF, 4, 1'b1);
`endif
  endtask

  task automatic test_start_held();
    int lat;
    start = 1'b1;
    mode  = M_AND;
    in    = 16'hFFFF;
    tick();
    in = 16'h0000;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      tick();
    end
    checks++;
    if (lat !== 4 || out !== 1'b1) begin
      errors++;
      $display("FAIL held_first_op lat/out got %0d/%0b expected 4/1", lat, out);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'b00) begin
      errors++;
      $display("FAIL held_done_to_idle busy got %0b expected 0", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_reaccept busy/done got %0b/%0b expected 1/0", busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || out !== 1'b0) begin
      errors++;
      $display("FAIL held_second_op done/out got %0b/%0b expected 1/0", done, out);
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_end busy/done got %0b/%0b expected 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    check_op("pre_reset_and", M_AND, 16'hFFFF, 4, 1'b1);
    start = 1'b1;
    mode  = M_AND;
    in    = 16'hFFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, out, dbg_state} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset busy/done/out/state got %b expected 00000",
               {busy, done, out, dbg_state});
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("post_reset_and", M_AND, 16'hFFFF, 4, 1'b1);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_or_a", M_OR, 16'h0100, 3, 1'b1);
    check_op("b2b_and_b", M_AND, 16'hF0FF, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_and();
    test_or();
    test_xor();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
